// File: rtl/alarm_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : alarm_ctrl
//  Description : Alarm sequencer that drives the piezo tone-player enable.
//                Detects the alarm minute, rings for a bounded time, and
//                handles snooze / stop button events.
//  Revision    : 1.0 - initial release
// ============================================================================
module alarm_ctrl #(
    parameter int RING_SEC   = 60,
    parameter int SNOOZE_SEC = 300,
    parameter int MAX_SNOOZE = 3
) (
    input  logic       clk,
    input  logic       rst,          // asynchronous, active-low
    input  logic       sec_tick,
    input  logic       alarm_on,
    input  logic [4:0] cur_hour,
    input  logic [5:0] cur_min,
    input  logic [5:0] cur_sec,
    input  logic [4:0] alm_hour,
    input  logic [5:0] alm_min,
    input  logic       btn_snooze,
    input  logic       btn_stop,
    output logic       enable,
    output logic       ringing,
    output logic       snoozing
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RING   = 2'd1,
        ST_SNOOZE = 2'd2
    } state_t;

    // Terminal counts for the one-second counters
    localparam logic [8:0] c_ring_last   = 9'(RING_SEC - 1);
    localparam logic [8:0] c_snooze_last = 9'(SNOOZE_SEC - 1);
    localparam logic [2:0] c_max_snooze  = 3'(MAX_SNOOZE);

    state_t     state_q,      state_d;
    logic [8:0] sec_cnt_q,    sec_cnt_d;
    logic [2:0] snooze_cnt_q, snooze_cnt_d;
    logic       match_q,      match_d;
    logic       snz_btn_q,    snz_btn_d;
    logic       stp_btn_q,    stp_btn_d;

    logic       w_match;
    logic       w_trig;
    logic       w_snz_ev;
    logic       w_stp_ev;

    // Alarm-minute match, its first-cycle trigger, and button rising edges
    always_comb begin
        w_match   = alarm_on && (cur_hour == alm_hour) && (cur_min == alm_min)
                    && (cur_sec == 6'd0);
        w_trig    = w_match && !match_q;
        w_snz_ev  = btn_snooze && !snz_btn_q;
        w_stp_ev  = btn_stop && !stp_btn_q;
        match_d   = w_match;
        snz_btn_d = btn_snooze;
        stp_btn_d = btn_stop;
    end

    // Next-state and counter update; priority is alarm_on > stop > snooze > timeout
    always_comb begin
        state_d      = state_q;
        sec_cnt_d    = sec_cnt_q;
        snooze_cnt_d = snooze_cnt_q;

        if (!alarm_on) begin
            state_d      = ST_IDLE;
            sec_cnt_d    = 9'd0;
            snooze_cnt_d = 3'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    sec_cnt_d    = 9'd0;
                    snooze_cnt_d = 3'd0;
                    if (w_trig) begin
                        state_d = ST_RING;
                    end
                end

                ST_RING: begin
                    if (w_stp_ev) begin
                        state_d      = ST_IDLE;
                        sec_cnt_d    = 9'd0;
                        snooze_cnt_d = 3'd0;
                    end else if (w_snz_ev && (snooze_cnt_q < c_max_snooze)) begin
                        state_d      = ST_SNOOZE;
                        sec_cnt_d    = 9'd0;
                        snooze_cnt_d = snooze_cnt_q + 3'd1;
                    end else if (sec_tick) begin
                        // A snooze press beyond the limit is no event, so the
                        // ring timeout still applies in that cycle.
                        if (sec_cnt_q == c_ring_last) begin
                            state_d      = ST_IDLE;
                            sec_cnt_d    = 9'd0;
                            snooze_cnt_d = 3'd0;
                        end else begin
                            sec_cnt_d = sec_cnt_q + 9'd1;
                        end
                    end
                end

                ST_SNOOZE: begin
                    if (w_stp_ev) begin
                        state_d      = ST_IDLE;
                        sec_cnt_d    = 9'd0;
                        snooze_cnt_d = 3'd0;
                    end else if (sec_tick) begin
                        if (sec_cnt_q == c_snooze_last) begin
                            state_d   = ST_RING;
                            sec_cnt_d = 9'd0;
                        end else begin
                            sec_cnt_d = sec_cnt_q + 9'd1;
                        end
                    end
                end

                default: begin
                    state_d      = ST_IDLE;
                    sec_cnt_d    = 9'd0;
                    snooze_cnt_d = 3'd0;
                end
            endcase
        end
    end

    // State, counters and edge-detect registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            sec_cnt_q    <= 9'd0;
            snooze_cnt_q <= 3'd0;
            match_q      <= 1'b0;
            snz_btn_q    <= 1'b0;
            stp_btn_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            sec_cnt_q    <= sec_cnt_d;
            snooze_cnt_q <= snooze_cnt_d;
            match_q      <= match_d;
            snz_btn_q    <= snz_btn_d;
            stp_btn_q    <= stp_btn_d;
        end
    end

    // Moore output decode straight from the state register
    assign enable   = (state_q == ST_RING);
    assign ringing  = (state_q == ST_RING);
    assign snoozing = (state_q == ST_SNOOZE);

endmodule
`default_nettype wire

// File: tb/tb_alarm_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alarm_ctrl
//  Description : Directed self-checking bench for alarm_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alarm_ctrl;

    logic       clk;
    logic       rst;
    logic       sec_tick;
    logic       alarm_on;
    logic [4:0] cur_hour;
    logic [5:0] cur_min;
    logic [5:0] cur_sec;
    logic [4:0] alm_hour;
    logic [5:0] alm_min;
    logic       btn_snooze;
    logic       btn_stop;
    logic       enable;
    logic       ringing;
    logic       snoozing;

    int n_checks;
    int n_fail;

    alarm_ctrl #(
        .RING_SEC   (60),
        .SNOOZE_SEC (300),
        .MAX_SNOOZE (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sec_tick   (sec_tick),
        .alarm_on   (alarm_on),
        .cur_hour   (cur_hour),
        .cur_min    (cur_min),
        .cur_sec    (cur_sec),
        .alm_hour   (alm_hour),
        .alm_min    (alm_min),
        .btn_snooze (btn_snooze),
        .btn_stop   (btn_stop),
        .enable     (enable),
        .ringing    (ringing),
        .snoozing   (snoozing)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare observed against expected and tally the result
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Outputs packed as {enable, ringing, snoozing}
    task automatic check_out(input string tag, input logic [2:0] exp);
        check(tag, {29'd0, enable, ringing, snoozing}, {29'd0, exp});
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            sec_tick = 1'b1;
            step(1);
            sec_tick = 1'b0;
        end
    endtask

    task automatic press_snooze();
        btn_snooze = 1'b1;
        step(1);
        btn_snooze = 1'b0;
    endtask

    task automatic press_stop();
        btn_stop = 1'b1;
        step(1);
        btn_stop = 1'b0;
    endtask

    // Leave and re-enter second 0 of the alarm minute to get a fresh trigger
    task automatic retrig();
        cur_sec = 6'd1;
        step(1);
        cur_sec = 6'd0;
        step(1);
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        rst        = 1'b0;
        sec_tick   = 1'b0;
        alarm_on   = 1'b1;
        cur_hour   = 5'd7;
        cur_min    = 6'd29;
        cur_sec    = 6'd59;
        alm_hour   = 5'd7;
        alm_min    = 6'd30;
        btn_snooze = 1'b0;
        btn_stop   = 1'b0;

        #12;
        check_out("reset_state", 3'b000);
        rst = 1'b1;
        step(2);
        check_out("idle_before_match", 3'b000);

        // 1: 07:29:59 -> 07:30:00, ring for exactly 60 ticks
        cur_min = 6'd30;
        cur_sec = 6'd0;
        #1;
        check_out("trig_cycle_not_yet", 3'b000);
        step(1);
        check_out("ring_after_trig", 3'b110);
        ticks(59);
        check_out("ring_after_59_ticks", 3'b110);
        ticks(1);
        check_out("autostop_60_ticks", 3'b000);
        step(3);
        check_out("no_retrig_after_timeout", 3'b000);

        // 2: snooze, 300 ticks of silence, re-ring
        retrig();
        check_out("ring_test2", 3'b110);
        press_snooze();
        check_out("snooze_1", 3'b001);
        ticks(100);
        press_snooze();
        check_out("snooze_press_in_snooze_ignored", 3'b001);
        ticks(199);
        check_out("snooze_after_299", 3'b001);
        ticks(1);
        check_out("rering_after_300", 3'b110);
        ticks(59);
        check_out("ring_timer_restarted", 3'b110);

        // 3: two more snoozes, the fourth press is ignored, then stop
        press_snooze();
        check_out("snooze_2", 3'b001);
        ticks(300);
        check_out("rering_2", 3'b110);
        press_snooze();
        check_out("snooze_3", 3'b001);
        ticks(300);
        check_out("rering_3", 3'b110);
        press_snooze();
        check_out("snooze_4_ignored", 3'b110);
        ticks(58);
        check_out("ring_after_ignored_press", 3'b110);
        press_stop();
        check_out("stop_to_idle", 3'b000);
        step(3);
        check_out("no_retrig_after_stop", 3'b000);

        // 4: stop and snooze on the same clock -> stop wins
        retrig();
        check_out("ring_test4", 3'b110);
        btn_snooze = 1'b1;
        btn_stop   = 1'b1;
        step(1);
        btn_snooze = 1'b0;
        btn_stop   = 1'b0;
        check_out("stop_beats_snooze", 3'b000);

        // 5: snooze held across SNOOZE->RING yields no new event
        retrig();
        press_snooze();
        check_out("snooze_test5", 3'b001);
        btn_snooze = 1'b1;
        ticks(300);
        check_out("held_rering", 3'b110);
        step(5);
        check_out("held_stays_ring", 3'b110);
        btn_snooze = 1'b0;
        step(1);
        check_out("release_stays_ring", 3'b110);
        press_snooze();
        check_out("repress_snoozes", 3'b001);
        press_stop();
        check_out("stop_from_snooze", 3'b000);

        // 6a: alarm_on dropped mid-SNOOZE
        retrig();
        press_snooze();
        ticks(10);
        check_out("snooze_test6", 3'b001);
        alarm_on = 1'b0;
        step(1);
        check_out("alarm_off_idle", 3'b000);
        cur_sec  = 6'd1;
        step(1);
        alarm_on = 1'b1;
        step(1);
        check_out("alarm_back_on_idle", 3'b000);

        // 6b: asynchronous reset mid-RING
        cur_sec = 6'd0;
        step(1);
        check_out("ring_test6b", 3'b110);
        #2;
        rst = 1'b0;
        #1;
        check_out("async_reset_clears", 3'b000);
        cur_sec = 6'd1;
        #3;
        rst = 1'b1;
        step(2);
        check_out("idle_after_reset", 3'b000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
